rw_arbiter: RTL
===============

# rw_arbiter

Two-requester arbiter that shares the single `axi_rw` front-end port between instruction fetch (IF, read-only) and the memory stage (MEM, read or write). Owns the downstream `rw_*` handshake, latches the winning request's fields for the full transaction, and returns read data and a one-cycle completion pulse to the granted requester. Sits between the IF/MEM stages and `axi_rw`; round-robin fairness prevents either stage from starving the other.

## Interface
- RW_DATA_WIDTH, 64, data width of all read/write data buses
- RW_ADDR_WIDTH, 32, address width

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- if_valid_i  in  1  IF read request; held until if_ready_o
- if_addr_i  in  RW_ADDR_WIDTH  IF fetch address
- if_size_i  in  8  IF byte-lane mask
- if_ready_o  out  1  one-cycle completion pulse to IF
- if_data_o  out  RW_DATA_WIDTH  IF read data, valid when if_ready_o
- mem_valid_i  in  1  MEM request; held until mem_ready_o
- mem_wen_i  in  1  1 = write, 0 = read
- mem_addr_i  in  RW_ADDR_WIDTH  MEM address
- mem_wdata_i  in  RW_DATA_WIDTH  MEM write data
- mem_size_i  in  8  MEM byte-lane mask / write strobe
- mem_ready_o  out  1  one-cycle completion pulse to MEM
- mem_data_o  out  RW_DATA_WIDTH  MEM read data, valid when mem_ready_o
- rw_valid_o  out  1  request to axi_rw, held until rw_ready_i
- rw_wen_o  out  1  latched write enable
- rw_addr_o  out  RW_ADDR_WIDTH  latched address
- rw_w_data_o  out  RW_DATA_WIDTH  latched write data (0 for IF)
- rw_size_o  out  8  latched byte mask
- rw_ready_i  in  1  axi_rw transaction complete (one-cycle pulse)
- rw_data_i  in  RW_DATA_WIDTH  axi_rw read data, valid with rw_ready_i

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, RESP.
- IDLE: if exactly one valid, grant it; if both valid, grant the requester NOT granted last (`last_mem` bit). On grant, latch wen/addr/wdata/size (IF: wen=0, wdata=0) and the grant owner; go to BUSY_IF/BUSY_MEM. No valid: stay.
- BUSY_*: rw_valid_o=1 with latched fields, stable until rw_ready_i. On rw_ready_i: capture rw_data_i into data register, update last_mem, go to RESP.
- RESP: assert owner's ready_o for exactly this cycle; owner's data_o = captured data (writes: captured value, don't-care). Next state IDLE unconditionally.
- Requester inputs are ignored outside IDLE; a valid dropped mid-transaction does not abort it — completion pulse is still issued.
- Non-owner's ready_o stays 0 throughout; its request waits.
- if_data_o / mem_data_o both driven from the captured data register; only ready_o qualifies them.

## Timing
- Reset (reset==0 at a clock edge): state=IDLE, last_mem=1 (IF wins first tie), all outputs 0, latched fields and data register 0. Reset mid-transaction aborts it; no ready pulse issued. axi_rw shares the same reset.
- Latency: valid seen in IDLE at edge t → rw_valid_o high from t+1; rw_ready_i at edge t+1+k (k≥0 cycles) → ready_o high for cycle after that edge; IDLE again one cycle later. Minimum 3 cycles request-to-next-grant.
- Requester must deassert valid in the cycle following its ready_o pulse or it is re-granted as a new request (arbitration in IDLE sees it).
- Back-to-back alternation under constant contention: IF, MEM, IF, MEM…
- rw_ready_i outside BUSY_* is ignored.

## Structure
- State encoding (2-bit IDLE/BUSY_IF/BUSY_MEM/RESP) and RW_READ/RW_WRITE constants go in `defines.v` alongside the existing AXI constants.
- Single module, no sub-module; round-robin pick is a few gates inlined in IDLE next-state logic.
- Top level instantiates rw_arbiter directly in front of axi_rw; its rw_* outputs connect one-to-one to axi_rw's request inputs (rw_wen_o added there).

## Test plan
- Reset held 3 cycles with both valids high → all outputs 0; after release IF granted first (rw_addr_o = if_addr_i, rw_wen_o=0).
- IF alone, addr 0x8000_0000, rw_ready_i after 4 cycles with data 0x0000_0013_0000_0093 → if_ready_o one cycle, if_data_o matches, mem_ready_o never high.
- MEM write addr 0x8000_1000, wdata 0xDEAD_BEEF, size 0x0F, inputs changed while BUSY → rw_* stay at latched values, mem_ready_o one pulse.
- Both valid continuously for 6 transactions → grant order IF, MEM, IF, MEM, IF, MEM.
- reset asserted during BUSY_MEM → next cycle rw_valid_o=0, no mem_ready_o; MEM re-request after reset completes normally.
- IF drops valid during BUSY_IF → transaction completes, if_ready_o still pulses once; spurious rw_ready_i in IDLE → no outputs change.

Source files
------------

// File: rtl/rw_arbiter_pkg.sv
// Shared constants for the IF/MEM front-end arbiter: FSM state codes and
// read/write encodings used on the rw_* request bus.
package rw_arbiter_pkg;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BUSY_IF  = 2'd1;
  localparam logic [1:0] ST_BUSY_MEM = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/rw_arbiter.sv
// Round-robin arbiter sharing one rw_* front-end port between instruction
// fetch (read-only) and the memory stage; holds the winner's fields per txn.
module rw_arbiter
  import rw_arbiter_pkg::*;
#(
  parameter int RW_DATA_WIDTH = 64,
  parameter int RW_ADDR_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     if_valid_i,
  input  logic [RW_ADDR_WIDTH-1:0] if_addr_i,
  input  logic [7:0]               if_size_i,
  output logic                     if_ready_o,
  output logic [RW_DATA_WIDTH-1:0] if_data_o,
  input  logic                     mem_valid_i,
  input  logic                     mem_wen_i,
  input  logic [RW_ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [RW_DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [7:0]               mem_size_i,
  output logic                     mem_ready_o,
  output logic [RW_DATA_WIDTH-1:0] mem_data_o,
  output logic                     rw_valid_o,
  output logic                     rw_wen_o,
  output logic [RW_ADDR_WIDTH-1:0] rw_addr_o,
  output logic [RW_DATA_WIDTH-1:0] rw_w_data_o,
  output logic [7:0]               rw_size_o,
  input  logic                     rw_ready_i,
  input  logic [RW_DATA_WIDTH-1:0] rw_data_i
);

  logic [1:0]               state_q, state_d;
  logic                     last_mem_q, last_mem_d;
  logic                     owner_mem_q, owner_mem_d;
  logic                     wen_q, wen_d;
  logic [RW_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RW_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]               size_q, size_d;
  logic [RW_DATA_WIDTH-1:0] data_q, data_d;
  logic                     grant_mem;

  // MEM wins only if alone, or on a tie when IF was served last.
  assign grant_mem = mem_valid_i & (~if_valid_i | ~last_mem_q);

  always_comb begin
    state_d     = state_q;
    last_mem_d  = last_mem_q;
    owner_mem_d = owner_mem_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    data_d      = data_q;
    case (state_q)
      ST_IDLE: begin
        if (if_valid_i || mem_valid_i) begin
          owner_mem_d = grant_mem;
          if (grant_mem) begin
            wen_d   = mem_wen_i ? RW_WRITE : RW_READ;
            addr_d  = mem_addr_i;
            wdata_d = mem_wdata_i;
            size_d  = mem_size_i;
            state_d = ST_BUSY_MEM;
          end else begin
            wen_d   = RW_READ;
            addr_d  = if_addr_i;
            wdata_d = '0;
            size_d  = if_size_i;
            state_d = ST_BUSY_IF;
          end
        end
      end
      ST_BUSY_IF, ST_BUSY_MEM: begin
        if (rw_ready_i) begin
          data_d     = rw_data_i;
          last_mem_d = owner_mem_q;
          state_d    = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      last_mem_q  <= 1'b1;
      owner_mem_q <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      owner_mem_q <= owner_mem_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      data_q      <= data_d;
    end
  end

  assign rw_valid_o  = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_MEM);
  assign rw_wen_o    = wen_q;
  assign rw_addr_o   = addr_q;
  assign rw_w_data_o = wdata_q;
  assign rw_size_o   = size_q;
  assign if_ready_o  = (state_q == ST_RESP) && !owner_mem_q;
  assign mem_ready_o = (state_q == ST_RESP) &&  owner_mem_q;
  assign if_data_o   = data_q;
  assign mem_data_o  = data_q;

endmodule
